// File: rtl/ci_sequencer_pkg.sv
// Shared widths, request record and FSM state encoding for the CI sequencer.
package ci_sequencer_pkg;

  localparam int CI_ID_W   = 8;
  localparam int CI_DATA_W = 32;
  localparam int CI_CYC_W  = 16;
  localparam int CI_REQ_W  = CI_ID_W + 2 * CI_DATA_W;

  // One queued request as it sits in the FIFO.
  typedef struct packed {
    logic [CI_ID_W-1:0]   ci_n;
    logic [CI_DATA_W-1:0] value_a;
    logic [CI_DATA_W-1:0] value_b;
  } ci_req_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } ci_state_t;

endpackage

// File: rtl/ci_req_fifo.sv
// Synchronous request FIFO with count-based full/empty and a show-ahead head word.
module ci_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 72
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  // A pop frees the slot being written, so a push into a full queue is fine then.
  assign do_push = push_i && (!full_o || do_pop);
  // Head is read directly so the sequencer can load operands on the pop edge.
  assign data_o  = mem_q[rd_ptr_q];

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (!do_push && do_pop) begin
      count_d = count_q - 1'b1;
    end
  end

  // Storage write; contents need no reset because count gates every read.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/ci_sequencer.sv
// CI initiator: queues requests, issues them one at a time, returns result/latency/timeout.
module ci_sequencer
  import ci_sequencer_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [7:0]  req_ci_n_i,
  input  logic [31:0] req_value_a_i,
  input  logic [31:0] req_value_b_i,
  output logic        ci_start_o,
  output logic [7:0]  ci_n_o,
  output logic [31:0] ci_value_a_o,
  output logic [31:0] ci_value_b_o,
  input  logic        ci_done_i,
  input  logic [31:0] ci_result_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_result_o,
  output logic [7:0]  rsp_ci_n_o,
  output logic        rsp_timeout_o,
  output logic [15:0] rsp_cycles_o,
  output logic        err_spurious_o
);

  localparam logic [CI_CYC_W-1:0] TIMEOUT_C = CI_CYC_W'(TIMEOUT_CYCLES);

  ci_state_t             state_q;
  logic                  ci_start_q;
  logic [CI_ID_W-1:0]    ci_n_q;
  logic [CI_DATA_W-1:0]  ci_value_a_q;
  logic [CI_DATA_W-1:0]  ci_value_b_q;
  logic [CI_CYC_W-1:0]   cyc_q;
  logic [CI_CYC_W-1:0]   cyc_d;
  logic                  rsp_valid_q;
  logic [CI_DATA_W-1:0]  rsp_result_q;
  logic [CI_ID_W-1:0]    rsp_ci_n_q;
  logic                  rsp_timeout_q;
  logic [CI_CYC_W-1:0]   rsp_cycles_q;
  logic                  err_spurious_q;

  ci_req_t               fifo_wdata;
  ci_req_t               fifo_head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_pop;

  assign fifo_wdata = '{ci_n: req_ci_n_i, value_a: req_value_a_i, value_b: req_value_b_i};
  assign fifo_pop   = (state_q == ST_IDLE) && !fifo_empty;
  // Saturating increment of the in-flight cycle count.
  assign cyc_d      = (cyc_q == '1) ? cyc_q : cyc_q + 1'b1;

  ci_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CI_REQ_W)
  ) u_fifo (
    .clk_i   (clock_i),
    .srst_i  (reset_i),
    .push_i  (req_valid_i && req_ready_o),
    .data_i  (fifo_wdata),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Issue FSM with registered CI and response outputs; one CI in flight at a time.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q        <= ST_IDLE;
      ci_start_q     <= 1'b0;
      ci_n_q         <= '0;
      ci_value_a_q   <= '0;
      ci_value_b_q   <= '0;
      cyc_q          <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_result_q   <= '0;
      rsp_ci_n_q     <= '0;
      rsp_timeout_q  <= 1'b0;
      rsp_cycles_q   <= '0;
      err_spurious_q <= 1'b0;
    end else begin
      if (ci_done_i && (state_q == ST_IDLE || state_q == ST_RESP)) begin
        err_spurious_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            ci_n_q       <= fifo_head.ci_n;
            ci_value_a_q <= fifo_head.value_a;
            ci_value_b_q <= fifo_head.value_b;
            ci_start_q   <= 1'b1;
            state_q      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          ci_start_q <= 1'b0;
          if (ci_done_i) begin
            rsp_result_q  <= ci_result_i;
            rsp_cycles_q  <= '0;
            rsp_timeout_q <= 1'b0;
            rsp_ci_n_q    <= ci_n_q;
            rsp_valid_q   <= 1'b1;
            cyc_q         <= '0;
            state_q       <= ST_RESP;
          end else begin
            // The issue cycle is cycle 0, so the first WAIT cycle is cycle 1.
            cyc_q   <= CI_CYC_W'(1);
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (ci_done_i) begin
            rsp_result_q  <= ci_result_i;
            rsp_cycles_q  <= cyc_q;
            rsp_timeout_q <= 1'b0;
            rsp_ci_n_q    <= ci_n_q;
            rsp_valid_q   <= 1'b1;
            state_q       <= ST_RESP;
          end else if (cyc_q >= TIMEOUT_C) begin
            rsp_result_q  <= '0;
            rsp_cycles_q  <= cyc_q;
            rsp_timeout_q <= 1'b1;
            rsp_ci_n_q    <= ci_n_q;
            rsp_valid_q   <= 1'b1;
            state_q       <= ST_RESP;
          end else begin
            cyc_q <= cyc_d;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready_o    = !fifo_full;
  assign ci_start_o     = ci_start_q;
  assign ci_n_o         = ci_n_q;
  assign ci_value_a_o   = ci_value_a_q;
  assign ci_value_b_o   = ci_value_b_q;
  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_result_o   = rsp_result_q;
  assign rsp_ci_n_o     = rsp_ci_n_q;
  assign rsp_timeout_o  = rsp_timeout_q;
  assign rsp_cycles_o   = rsp_cycles_q;
  assign err_spurious_o = err_spurious_q;

endmodule

// File: tb/tb_ci_sequencer.sv
// Directed bench for ci_sequencer with a TIMEOUT_CYCLES=8 instance.
module tb_ci_sequencer;

  logic        clk = 1'b0;
  logic        srst;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_ci_n;
  logic [31:0] req_value_a;
  logic [31:0] req_value_b;
  logic        ci_start;
  logic [7:0]  ci_n;
  logic [31:0] ci_value_a;
  logic [31:0] ci_value_b;
  logic        ci_done;
  logic [31:0] ci_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic [7:0]  rsp_ci_n;
  logic        rsp_timeout;
  logic [15:0] rsp_cycles;
  logic        err_spurious;

  // Responder: automatic same-cycle mode answers {A5A5A5, id}; otherwise driven by hand.
  logic        auto_done;
  logic        ci_done_man;
  logic [31:0] ci_result_man;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign ci_done   = auto_done ? ci_start : ci_done_man;
  assign ci_result = auto_done ? {24'hA5A5A5, ci_n} : ci_result_man;

  ci_sequencer #(
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clock_i        (clk),
    .reset_i        (srst),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_ci_n_i     (req_ci_n),
    .req_value_a_i  (req_value_a),
    .req_value_b_i  (req_value_b),
    .ci_start_o     (ci_start),
    .ci_n_o         (ci_n),
    .ci_value_a_o   (ci_value_a),
    .ci_value_b_o   (ci_value_b),
    .ci_done_i      (ci_done),
    .ci_result_i    (ci_result),
    .rsp_valid_o    (rsp_valid),
    .rsp_ready_i    (rsp_ready),
    .rsp_result_o   (rsp_result),
    .rsp_ci_n_o     (rsp_ci_n),
    .rsp_timeout_o  (rsp_timeout),
    .rsp_cycles_o   (rsp_cycles),
    .err_spurious_o (err_spurious)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] id, input logic [31:0] a, input logic [31:0] b);
    req_valid   = 1'b1;
    req_ci_n    = id;
    req_value_a = a;
    req_value_b = b;
    tick();
    req_valid   = 1'b0;
    $display("push  id=%02h a=%08h b=%08h", id, a, b);
  endtask

  task automatic wait_start(output int n, output bit ok);
    n = 0;
    while (!ci_start && n < 20) begin
      tick();
      n++;
    end
    ok = ci_start;
  endtask

  task automatic wait_rsp(output bit ok);
    int n = 0;
    while (!rsp_valid && n < 40) begin
      tick();
      n++;
    end
    ok = rsp_valid;
  endtask

  task automatic accept();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    srst = 1'b1;
    tick(); tick(); tick();
    n_cmp++; if (ci_start !== 1'b0) begin n_err++; $display("FAIL reset_ci_start got=%b exp=0", ci_start); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    n_cmp++; if (ci_n !== 8'h00 || rsp_ci_n !== 8'h00) begin n_err++; $display("FAIL reset_ids got=%02h/%02h exp=00/00", ci_n, rsp_ci_n); end
    n_cmp++; if (err_spurious !== 1'b0) begin n_err++; $display("FAIL reset_err got=%b exp=0", err_spurious); end
    srst = 1'b0;
    tick();
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    $display("reset done");
  endtask

  task automatic test_same_cycle();
    int n; bit ok;
    auto_done = 1'b0;
    push(8'h0B, 32'h0000_0011, 32'h0000_0022);
    wait_start(n, ok);
    n_cmp++; if (!ok || n != 1) begin n_err++; $display("FAIL same_latency got=%0d started=%b exp=1", n, ok); end
    ci_result_man = 32'hCAFE0001;
    ci_done_man   = 1'b1;
    tick();
    ci_done_man   = 1'b0;
    $display("rsp   id=%02h res=%08h cyc=%0d to=%b", rsp_ci_n, rsp_result, rsp_cycles, rsp_timeout);
    n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL same_rsp_valid got=%b exp=1", rsp_valid); end
    n_cmp++; if (rsp_result !== 32'hCAFE0001) begin n_err++; $display("FAIL same_result got=%08h exp=CAFE0001", rsp_result); end
    n_cmp++; if (rsp_cycles !== 16'd0) begin n_err++; $display("FAIL same_cycles got=%0d exp=0", rsp_cycles); end
    n_cmp++; if (rsp_timeout !== 1'b0) begin n_err++; $display("FAIL same_timeout got=%b exp=0", rsp_timeout); end
    n_cmp++; if (rsp_ci_n !== 8'h0B) begin n_err++; $display("FAIL same_ci_n got=%02h exp=0B", rsp_ci_n); end
    n_cmp++; if (ci_start !== 1'b0) begin n_err++; $display("FAIL same_start_drop got=%b exp=0", ci_start); end
    accept();
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL same_rsp_clear got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_multi_cycle();
    int n; bit ok; int pulses = 0;
    auto_done = 1'b0;
    push(8'h21, 32'hAAAA5555, 32'h12345678);
    wait_start(n, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL multi_start got=0 exp=1"); end
    for (int k = 0; k < 6; k++) begin
      pulses += int'(ci_start);
      n_cmp++;
      if (ci_n !== 8'h21 || ci_value_a !== 32'hAAAA5555 || ci_value_b !== 32'h12345678) begin
        n_err++;
        $display("FAIL multi_operands k=%0d got=%02h/%08h/%08h exp=21/AAAA5555/12345678", k, ci_n, ci_value_a, ci_value_b);
      end
      if (k == 5) begin
        ci_result_man = 32'h5EED0005;
        ci_done_man   = 1'b1;
      end
      tick();
    end
    ci_done_man = 1'b0;
    $display("rsp   id=%02h res=%08h cyc=%0d to=%b", rsp_ci_n, rsp_result, rsp_cycles, rsp_timeout);
    n_cmp++; if (pulses != 1) begin n_err++; $display("FAIL multi_pulses got=%0d exp=1", pulses); end
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_cycles !== 16'd5) begin n_err++; $display("FAIL multi_cycles got=v%b/%0d exp=v1/5", rsp_valid, rsp_cycles); end
    n_cmp++; if (rsp_result !== 32'h5EED0005 || rsp_timeout !== 1'b0) begin n_err++; $display("FAIL multi_result got=%08h/%b exp=5EED0005/0", rsp_result, rsp_timeout); end
    accept();
  endtask

  task automatic test_timeout();
    int n; bit ok; int early = 0;
    auto_done     = 1'b0;
    ci_result_man = 32'hDEADBEEF;
    push(8'h33, 32'h1, 32'h2);
    wait_start(n, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL to_start got=0 exp=1"); end
    for (int k = 0; k < 8; k++) begin
      tick();
      early += int'(rsp_valid);
    end
    n_cmp++; if (early != 0) begin n_err++; $display("FAIL to_early_rsp got=%0d exp=0", early); end
    tick();
    $display("rsp   id=%02h res=%08h cyc=%0d to=%b", rsp_ci_n, rsp_result, rsp_cycles, rsp_timeout);
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b1) begin n_err++; $display("FAIL to_flag got=v%b/t%b exp=v1/t1", rsp_valid, rsp_timeout); end
    n_cmp++; if (rsp_result !== 32'h0 || rsp_ci_n !== 8'h33) begin n_err++; $display("FAIL to_result got=%08h/%02h exp=00000000/33", rsp_result, rsp_ci_n); end
    accept();
    // Done arriving exactly on the timeout cycle must win.
    push(8'h34, 32'h3, 32'h4);
    wait_start(n, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL to2_start got=0 exp=1"); end
    for (int k = 0; k < 8; k++) tick();
    ci_result_man = 32'h00000D0D;
    ci_done_man   = 1'b1;
    tick();
    ci_done_man   = 1'b0;
    $display("rsp   id=%02h res=%08h cyc=%0d to=%b", rsp_ci_n, rsp_result, rsp_cycles, rsp_timeout);
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b0) begin n_err++; $display("FAIL to2_flag got=v%b/t%b exp=v1/t0", rsp_valid, rsp_timeout); end
    n_cmp++; if (rsp_result !== 32'h00000D0D || rsp_cycles !== 16'd8) begin n_err++; $display("FAIL to2_result got=%08h/%0d exp=00000D0D/8", rsp_result, rsp_cycles); end
    accept();
  endtask

  task automatic test_queue_full();
    int got = 0; int guard = 0;
    auto_done = 1'b1;
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL full_ready_%0d got=0 exp=1", i); end
      push(8'h40 + 8'(i), 32'h100 + 32'(i), 32'h200 + 32'(i));
    end
    n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL full_ready_low got=%b exp=0", req_ready); end
    // A sixth offer while full must not be taken.
    req_valid = 1'b1; req_ci_n = 8'h45;
    tick(); tick(); tick();
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    while (guard < 150) begin
      if (rsp_valid) begin
        $display("rsp   id=%02h res=%08h cyc=%0d to=%b", rsp_ci_n, rsp_result, rsp_cycles, rsp_timeout);
        n_cmp++;
        if (got >= 5 || rsp_ci_n !== 8'h40 + 8'(got) || rsp_result !== {24'hA5A5A5, 8'h40 + 8'(got)}) begin
          n_err++;
          $display("FAIL full_order idx=%0d got=%02h/%08h exp=%02h", got, rsp_ci_n, rsp_result, 8'h40 + 8'(got));
        end
        got++;
      end
      tick();
      guard++;
    end
    rsp_ready = 1'b0;
    n_cmp++; if (got != 5) begin n_err++; $display("FAIL full_count got=%0d exp=5", got); end
  endtask

  task automatic test_back_to_back();
    bit ok; int n; int starts = 0;
    auto_done = 1'b1;
    rsp_ready = 1'b0;
    push(8'h50, 32'h5, 32'h6);
    push(8'h51, 32'h7, 32'h8);
    wait_rsp(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL bp_first_rsp got=0 exp=1"); end
    for (int k = 0; k < 10; k++) begin
      starts += int'(ci_start);
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_ci_n !== 8'h50 || rsp_result !== 32'hA5A5A550 || rsp_cycles !== 16'd0 || rsp_timeout !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold k=%0d got=v%b id=%02h res=%08h exp=v1 id=50 res=A5A5A550", k, rsp_valid, rsp_ci_n, rsp_result);
      end
      tick();
    end
    n_cmp++; if (starts != 0) begin n_err++; $display("FAIL bp_no_issue got=%0d exp=0", starts); end
    $display("rsp   id=%02h res=%08h cyc=%0d to=%b", rsp_ci_n, rsp_result, rsp_cycles, rsp_timeout);
    accept();
    wait_start(n, ok);
    n_cmp++; if (!ok || ci_n !== 8'h51) begin n_err++; $display("FAIL bp_next_start got=%b/%02h exp=1/51", ok, ci_n); end
    wait_rsp(ok);
    $display("rsp   id=%02h res=%08h cyc=%0d to=%b", rsp_ci_n, rsp_result, rsp_cycles, rsp_timeout);
    n_cmp++; if (!ok || rsp_ci_n !== 8'h51) begin n_err++; $display("FAIL bp_second got=%b/%02h exp=1/51", ok, rsp_ci_n); end
    accept();
  endtask

  task automatic test_reset_wait();
    int n; bit ok; int starts = 0; int rsps = 0;
    auto_done = 1'b0;
    push(8'h60, 32'h9, 32'hA);
    push(8'h61, 32'hB, 32'hC);
    wait_start(n, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL rw_start got=0 exp=1"); end
    tick(); tick(); tick();
    srst = 1'b1;
    tick();
    srst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      starts += int'(ci_start);
      rsps   += int'(rsp_valid);
      tick();
    end
    n_cmp++; if (starts != 0) begin n_err++; $display("FAIL rw_no_start got=%0d exp=0", starts); end
    n_cmp++; if (rsps != 0) begin n_err++; $display("FAIL rw_no_rsp got=%0d exp=0", rsps); end
    n_cmp++; if (err_spurious !== 1'b0) begin n_err++; $display("FAIL rw_err_clear got=%b exp=0", err_spurious); end
    ci_done_man = 1'b1;
    tick();
    ci_done_man = 1'b0;
    tick(); tick(); tick();
    n_cmp++; if (err_spurious !== 1'b1) begin n_err++; $display("FAIL spurious_set got=%b exp=1", err_spurious); end
    srst = 1'b1;
    tick();
    srst = 1'b0;
    tick();
    n_cmp++; if (err_spurious !== 1'b0) begin n_err++; $display("FAIL spurious_reset got=%b exp=0", err_spurious); end
    $display("reset-during-wait done");
  endtask

  initial begin
    srst          = 1'b1;
    req_valid     = 1'b0;
    req_ci_n      = '0;
    req_value_a   = '0;
    req_value_b   = '0;
    rsp_ready     = 1'b0;
    auto_done     = 1'b0;
    ci_done_man   = 1'b0;
    ci_result_man = '0;
    test_reset();
    test_same_cycle();
    test_multi_cycle();
    test_timeout();
    test_queue_full();
    test_back_to_back();
    test_reset_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
